// File: rtl/scroll_pkg.sv
// Shared definitions for the frame-synchronous scroll scheduler.
// State encoding, direction codes and default image geometry.
package scroll_pkg;

    localparam int ROWS_DEF    = 240;
    localparam int ROW_PIX_DEF = 320;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

endpackage

// File: rtl/scroll_step.sv
// Combinational next-position / next-direction / next-offset calculator.
// Ports: pos_i current row, dir_i effective direction, bounce_i edge mode;
//        pos_o next row, dir_o next internal direction, off_o pos_o*ROW_PIX.
module scroll_step
    import scroll_pkg::*;
#(
    parameter int ROWS    = ROWS_DEF,
    parameter int ROW_PIX = ROW_PIX_DEF,
    parameter int POS_W   = 8,
    parameter int ADDR_W  = 17
) (
    input  logic [POS_W-1:0]  pos_i,
    input  logic              dir_i,
    input  logic              bounce_i,
    output logic [POS_W-1:0]  pos_o,
    output logic              dir_o,
    output logic [ADDR_W-1:0] off_o
);

    localparam logic [POS_W-1:0] LAST = POS_W'(ROWS - 1);

    always_comb begin
        pos_o = pos_i;
        dir_o = dir_i;
        if (dir_i == DIR_DOWN) begin
            if (pos_i == LAST) begin
                if (bounce_i) begin
                    pos_o = LAST - 1'b1;
                    dir_o = DIR_UP;
                end else begin
                    pos_o = '0;
                end
            end else begin
                pos_o = pos_i + 1'b1;
            end
        end else begin
            if (pos_i == '0) begin
                if (bounce_i) begin
                    pos_o = POS_W'(1);
                    dir_o = DIR_DOWN;
                end else begin
                    pos_o = LAST;
                end
            end else begin
                pos_o = pos_i - 1'b1;
            end
        end
    end

    logic [ADDR_W-1:0] p_ext;
    assign p_ext = ADDR_W'(pos_o);

    // 320 = 256 + 64, so the default geometry needs no multiplier.
    generate
        if (ROW_PIX == 320) begin : g_shift_add
            assign off_o = (p_ext << 8) + (p_ext << 6);
        end else begin : g_mult
            assign off_o = p_ext * ADDR_W'(ROW_PIX);
        end
    endgenerate

endmodule

// File: rtl/scroll_ctrl.sv
// Frame-synchronous vertical scroll scheduler: FSM, frame counter, step-request edge detect.
// Ports: clk, rst (async, high), frame_tick, en, dir, bounce, speed, step_req in;
//        step_ack, position, row_offset, moving out (all registered).
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int ROWS    = ROWS_DEF,
    parameter int ROW_PIX = ROW_PIX_DEF,
    parameter int POS_W   = 8,
    parameter int ADDR_W  = 17,
    parameter int SPD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              en,
    input  logic              dir,
    input  logic              bounce,
    input  logic [SPD_W-1:0]  speed,
    input  logic              step_req,
    output logic              step_ack,
    output logic [POS_W-1:0]  position,
    output logic [ADDR_W-1:0] row_offset,
    output logic              moving
);

    state_t            state_q;
    logic [SPD_W-1:0]  fcnt_q;
    logic              cur_dir_q;
    logic              req_q;
    logic              bounce_q;
    logic [POS_W-1:0]  pos_q;
    logic [ADDR_W-1:0] off_q;
    logic              ack_q;
    logic              moving_q;

    logic              step_rise;
    logic              eff_dir;
    logic [POS_W-1:0]  pos_d;
    logic              dir_d;
    logic [ADDR_W-1:0] off_d;

    assign step_rise = step_req & ~req_q;

    // Wrap mode tracks the dir input live; bounce mode owns its direction.
    assign eff_dir = bounce ? cur_dir_q : dir;

    scroll_step #(
        .ROWS    (ROWS),
        .ROW_PIX (ROW_PIX),
        .POS_W   (POS_W),
        .ADDR_W  (ADDR_W)
    ) u_step (
        .pos_i    (pos_q),
        .dir_i    (eff_dir),
        .bounce_i (bounce),
        .pos_o    (pos_d),
        .dir_o    (dir_d),
        .off_o    (off_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fcnt_q    <= '0;
            cur_dir_q <= DIR_DOWN;
            req_q     <= 1'b0;
            bounce_q  <= 1'b0;
            pos_q     <= '0;
            off_q     <= '0;
            ack_q     <= 1'b0;
            moving_q  <= 1'b0;
        end else begin
            req_q    <= step_req;
            bounce_q <= bounce;
            ack_q    <= 1'b0;

            // Leaving bounce mode resynchronises the direction with dir.
            if (bounce_q && !bounce) begin
                cur_dir_q <= dir;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        state_q   <= ST_RUN;
                        moving_q  <= 1'b1;
                        cur_dir_q <= dir;
                        fcnt_q    <= '0;
                    end else if (step_rise) begin
                        state_q   <= ST_PEND;
                        cur_dir_q <= dir;
                    end
                end
                ST_RUN: begin
                    if (!en) begin
                        state_q  <= ST_IDLE;
                        moving_q <= 1'b0;
                        fcnt_q   <= '0;
                    end else if (frame_tick) begin
                        // >= lets a lowered speed fire on the next tick.
                        if (fcnt_q >= speed) begin
                            pos_q     <= pos_d;
                            off_q     <= off_d;
                            cur_dir_q <= dir_d;
                            fcnt_q    <= '0;
                        end else begin
                            fcnt_q <= fcnt_q + 1'b1;
                        end
                    end
                end
                ST_PEND: begin
                    // Enabling continuous scroll supersedes the pending step.
                    if (en) begin
                        state_q   <= ST_RUN;
                        moving_q  <= 1'b1;
                        cur_dir_q <= dir;
                        fcnt_q    <= '0;
                    end else if (frame_tick) begin
                        pos_q     <= pos_d;
                        off_q     <= off_d;
                        cur_dir_q <= dir_d;
                        ack_q     <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    moving_q <= 1'b0;
                end
            endcase
        end
    end

    assign step_ack   = ack_q;
    assign position   = pos_q;
    assign row_offset = off_q;
    assign moving     = moving_q;

endmodule
